tc_psum_pingpong: RTL and testbench
===================================

Name: tc_psum_pingpong

Overview:
- Next-generation partial-sum accumulator for the tensor core.
- Accepts M_TILE x N_TILE partial-sum tiles through a valid/ready handshake and accumulates them into one of two M x N banks (ping-pong).
- A completed bank is streamed out one N-wide row per handshake while the other bank accumulates the next output matrix.
- Sits between the tile MAC array and the output writeback.

Parameters:
- M, 16: output matrix rows.
- N, 16: output matrix columns.
- M_TILE, 4: tile rows; M must be divisible by M_TILE.
- N_TILE, 4: tile columns; N must be divisible by N_TILE.
- DW_ADD, 32: signed element width, for both accumulator and input.
- DW_PTR, 8: width of the tile pointers and the row index.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: global advance enable.
- in_valid, input, 1: input tile valid.
- in_ready, output, 1: input tile accepted when in_valid && in_ready.
- in_ptr_row, input, DW_PTR: tile row index, range 0..M/M_TILE-1.
- in_ptr_col, input, DW_PTR: tile column index, range 0..N/N_TILE-1.
- in_first, input, 1: 1 = overwrite the elements; 0 = accumulate.
- in_last, input, 1: final K step for this tile position.
- in_data, input, DW_ADD*M_TILE*N_TILE: signed tile; element (i,j) sits at bit offset DW_ADD*(i*N_TILE+j).
- out_valid, output, 1: output row valid.
- out_ready, input, 1: output row consumed when out_valid && out_ready.
- out_data, output, DW_ADD*N: signed row; column c sits at bit offset DW_ADD*c.
- out_row, output, DW_PTR: index of the row presented on out_data.
- out_last, output, 1: presented row is row M-1.
- err, output, 1: sticky flag for an out-of-range pointer.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: out_valid=0, out_data=0, out_row=0, out_last=0, err=0.
  - Both banks FREE; wr_bank=0, rd_bank=0; tile counters=0.
  - Bank contents are not cleared; in_first makes clearing unnecessary.
  - Reset mid-operation discards all in-flight and pending data.
- Bank states: FREE -> FILL, on the first accepted tile -> READY, on the completing tile -> FREE, after the out_last handshake.
- Input side:
  - in_ready = enable && state[wr_bank] != READY. This is combinational.
  - On accept, for each element (i,j), addr = (in_ptr_row*M_TILE+i)*N + in_ptr_col*N_TILE+j.
    - in_first=1: bank[addr] <= in_data element.
    - in_first=0: bank[addr] <= bank[addr] + element. Addition is two's-complement and wraps at DW_ADD bits.
  - Every accepted beat with in_last=1 increments the bank's tile counter.
  - When the counter reaches (M/M_TILE)*(N/N_TILE):
    - On that same edge the bank becomes READY, its counter clears and wr_bank toggles.
    - The tile's own data is included in the bank.
  - Duplicate in_last beats to the same tile position are counted; they are not detected.
  - Out-of-range pointer on accept: the beat is consumed with no write and no count, and err is set to 1.
- Output side:
  - When out_valid=0 and state[rd_bank]==READY, load row 0 of rd_bank on the next edge and raise out_valid.
    - Latency from the completing input accept to out_valid=1 is 2 cycles.
  - out_data, out_row and out_last stay stable while out_valid && !out_ready.
  - On a handshake with out_row<M-1: the next row is loaded on the same edge. Rows are back to back, one per cycle at full throughput.
  - On a handshake with out_last=1:
    - out_valid drops, rd_bank becomes FREE and rd_bank toggles.
    - If the other bank is already READY, its row 0 loads after one bubble cycle.
- Simultaneous events:
  - A bank freed by the drain and a tile accepted on the same edge are both legal.
  - Filling one bank while draining the other is the normal overlapped case.
- enable=0: no accept (in_ready=0) and no output advance. The out_valid and data registers hold; out_ready is ignored.
- Both banks READY: in_ready=0 until the drain frees one bank.

Optional Feature:
- Macro TC_PSUM_SAT_EN.
- Defined: both the accumulate and overwrite paths saturate to the signed range, max 2^(DW_ADD-1)-1 and min -2^(DW_ADD-1).
- Not defined: additions wrap modulo 2^DW_ADD, and no saturation logic is synthesised.

Test Plan:
- Basic drain. M=N=8, tiles 4x4, DW_ADD=16. Send the 4 tiles with in_first=in_last=1, each element = ptr_row*10+ptr_col, out_ready=1.
  -> Rows 0..3 read {0,0,0,0,1,1,1,1} and rows 4..7 read {10,...,11}. out_last on row 7. out_valid rises 2 cycles after the 4th accept.
- K accumulation. Per tile: step 1 = 3 with in_first, step 2 = 5, step 3 = -2 with in_last.
  -> Every element reads 6. The bank becomes READY only after the 4th in_last.
- Ping-pong backpressure. Hold out_ready=0 and fill two matrices.
  -> in_ready=0 on the 9th tile. After 8 output handshakes, in_ready=1 on the following cycle.
- Output stall. Toggle out_ready randomly.
  -> out_data and out_row stay stable while stalled. Rows arrive in order 0..7 with no loss or duplication.
- Error path. Send a tile with in_ptr_row=2 (M/M_TILE=2), then assert reset_n=0 mid-drain.
  -> err=1, no bank change. After reset: out_valid=0, err=0, in_ready=1 once enable=1.
- Saturation (TC_PSUM_SAT_EN, DW_ADD=16). Send 30000 then +10000.
  -> Element reads 32767. Without the macro it reads -25536.

Source files
------------

// File: rtl/tc_psum_pingpong.sv
// tc_psum_pingpong: ping-pong partial-sum accumulator for the tensor core.
//
// Tiles of M_TILE x N_TILE signed partial sums are accumulated into one of
// two M x N banks. Once a bank holds every tile position's final K step, it
// is streamed out one N-wide row per handshake. Meanwhile the other bank
// accumulates the next output matrix.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             global advance enable (gates input accept and output advance)
//   in_valid/in_ready  input tile handshake (in_ready is combinational)
//   in_ptr_row/col     tile position in tile units
//   in_first           1 = overwrite elements, 0 = accumulate
//   in_last            final K step for this tile position
//   in_data            tile, element (i,j) at bit offset DW_ADD*(i*N_TILE+j)
//   out_valid/ready    output row handshake
//   out_data           row, column c at bit offset DW_ADD*c
//   out_row, out_last  index of the presented row, and a flag for row M-1
//   err                sticky out-of-range pointer flag
//
// Optional build macro TC_PSUM_SAT_EN: both the overwrite and the accumulate
// paths saturate to the signed DW_ADD range. Without it, additions wrap.
module tc_psum_pingpong #(
    parameter int unsigned M      = 16,
    parameter int unsigned N      = 16,
    parameter int unsigned M_TILE = 4,
    parameter int unsigned N_TILE = 4,
    parameter int unsigned DW_ADD = 32,
    parameter int unsigned DW_PTR = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DW_PTR-1:0]               in_ptr_row,
    input  logic [DW_PTR-1:0]               in_ptr_col,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [DW_ADD*M_TILE*N_TILE-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DW_ADD*N-1:0]             out_data,
    output logic [DW_PTR-1:0]               out_row,
    output logic                            out_last,
    output logic                            err
);

    localparam int unsigned RowTiles = M / M_TILE;
    localparam int unsigned ColTiles = N / N_TILE;
    localparam int unsigned Tiles    = RowTiles * ColTiles;
    localparam int unsigned CntW     = $clog2(Tiles + 1);
    localparam int unsigned AddrW    = (M * N > 1) ? $clog2(M * N) : 1;

    typedef enum logic [1:0] {StFree, StFill, StReady} bank_state_e;

    bank_state_e              state_q [2];
    logic [CntW-1:0]          cnt_q   [2];
    logic                     wr_bank_q;
    logic                     rd_bank_q;
    // Bank storage has no reset: in_first overwrites stale contents.
    logic signed [DW_ADD-1:0] mem     [2][M*N];

    logic                accept, range_ok, wr_en, tile_done, out_hs, load_en;
    logic [DW_PTR-1:0]   load_row;
    logic [DW_ADD*N-1:0] row_data;

    function automatic logic [AddrW-1:0] tile_addr(input logic [DW_PTR-1:0] pr,
                                                   input logic [DW_PTR-1:0] pc,
                                                   input int unsigned i,
                                                   input int unsigned j);
        return AddrW'((32'(pr) * M_TILE + i) * N + 32'(pc) * N_TILE + j);
    endfunction

    function automatic logic signed [DW_ADD-1:0] upd(input logic signed [DW_ADD-1:0] acc,
                                                     input logic signed [DW_ADD-1:0] x,
                                                     input logic first);
`ifdef TC_PSUM_SAT_EN
        logic signed [DW_ADD:0] sum;
        sum = first ? {x[DW_ADD-1], x} : ({acc[DW_ADD-1], acc} + {x[DW_ADD-1], x});
        // Overflow when the guard bit disagrees with the sign bit.
        if (sum[DW_ADD] != sum[DW_ADD-1]) begin
            upd = sum[DW_ADD] ? {1'b1, {(DW_ADD-1){1'b0}}} : {1'b0, {(DW_ADD-1){1'b1}}};
        end else begin
            upd = sum[DW_ADD-1:0];
        end
`else
        upd = first ? x : acc + x;
`endif
    endfunction

    assign in_ready  = enable && (state_q[wr_bank_q] != StReady);
    assign accept    = in_valid && in_ready;
    assign range_ok  = (32'(in_ptr_row) < RowTiles) && (32'(in_ptr_col) < ColTiles);
    assign wr_en     = accept && range_ok;
    assign tile_done = wr_en && in_last && ((32'(cnt_q[wr_bank_q]) + 32'd1) == Tiles);
    assign out_hs    = out_valid && out_ready;

    // Row fetch: row 0 of a newly ready bank, or the next row on a handshake.
    always_comb begin
        load_en  = 1'b0;
        load_row = '0;
        if (enable) begin
            if (!out_valid) begin
                load_en = (state_q[rd_bank_q] == StReady);
            end else if (out_hs && !out_last) begin
                load_en  = 1'b1;
                load_row = out_row + DW_PTR'(1);
            end
        end
    end

    always_comb begin
        row_data = '0;
        for (int c = 0; c < N; c++) begin
            row_data[DW_ADD*c +: DW_ADD] = mem[rd_bank_q][AddrW'(32'(load_row) * N + c)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < M_TILE; i++) begin
                for (int unsigned j = 0; j < N_TILE; j++) begin
                    mem[wr_bank_q][tile_addr(in_ptr_row, in_ptr_col, i, j)] <=
                        upd(mem[wr_bank_q][tile_addr(in_ptr_row, in_ptr_col, i, j)],
                            in_data[DW_ADD*(i*N_TILE+j) +: DW_ADD], in_first);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q[0] <= StFree;
            state_q[1] <= StFree;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_last   <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Out-of-range beats are consumed without touching any bank.
            if (accept && !range_ok) begin
                err <= 1'b1;
            end
            if (wr_en) begin
                if (state_q[wr_bank_q] == StFree) begin
                    state_q[wr_bank_q] <= StFill;
                end
                if (tile_done) begin
                    state_q[wr_bank_q] <= StReady;
                    cnt_q[wr_bank_q]   <= '0;
                    wr_bank_q          <= ~wr_bank_q;
                end else if (in_last) begin
                    cnt_q[wr_bank_q] <= cnt_q[wr_bank_q] + CntW'(1);
                end
            end
            // The drained bank is READY, so it can never be the bank being written.
            if (load_en) begin
                out_valid <= 1'b1;
                out_data  <= row_data;
                out_row   <= load_row;
                out_last  <= (32'(load_row) == M - 1);
            end else if (enable && out_hs && out_last) begin
                out_valid          <= 1'b0;
                state_q[rd_bank_q] <= StFree;
                rd_bank_q          <= ~rd_bank_q;
            end
        end
    end

endmodule

// File: tb/tb_tc_psum_pingpong.sv
module tb_tc_psum_pingpong;

    localparam int M = 8, N = 8, MT = 4, NT = 4, DW = 16, PW = 8;

    logic              clk = 1'b0;
    logic              reset_n, enable, in_valid, in_ready, in_first, in_last;
    logic [PW-1:0]     in_ptr_row, in_ptr_col;
    logic [DW*MT*NT-1:0] in_data;
    logic              out_valid, out_ready, out_last, err;
    logic [DW*N-1:0]   out_data;
    logic [PW-1:0]     out_row;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_mat [M][N];

    tc_psum_pingpong #(
        .M(M), .N(N), .M_TILE(MT), .N_TILE(NT), .DW_ADD(DW), .DW_PTR(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ptr_row(in_ptr_row), .in_ptr_col(in_ptr_col),
        .in_first(in_first), .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint elem(input int c);
        logic signed [DW-1:0] e;
        e = out_data[DW*c +: DW];
        return longint'(e);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_tile(input int pr, input int pc, input bit f, input bit l,
                             input longint v);
        logic [DW-1:0] v16;
        int t;
        v16        = v[DW-1:0];
        t          = 0;
        in_valid   = 1'b1;
        in_ptr_row = PW'(pr);
        in_ptr_col = PW'(pc);
        in_first   = f;
        in_last    = l;
        in_data    = {(MT*NT){v16}};
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_matrix(input int base);
        for (int pr = 0; pr < 2; pr++)
            for (int pc = 0; pc < 2; pc++)
                send_tile(pr, pc, 1'b1, 1'b1, base + pr * 10 + pc);
    endtask

    task automatic set_exp(input int base);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                exp_mat[r][c] = base + (r / MT) * 10 + (c / NT);
    endtask

    // Drains one matrix, checking order and contents on each handshake and
    // stability of the presented row while stalled.
    task automatic drain(input bit rnd);
        int r, t, hrow;
        bit stalled;
        logic [DW*N-1:0] held;
        r = 0; t = 0; stalled = 1'b0; held = '0; hrow = 0;
        while (r < M && t < 500) begin
            if (stalled) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", longint'(out_data == held), 1);
                check_eq("stall_row", out_row, hrow);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (out_ready) begin
                    check_eq("row_idx", out_row, r);
                    check_eq("row_last", out_last, (r == M - 1) ? 1 : 0);
                    for (int c = 0; c < N; c++) check_eq("row_data", elem(c), exp_mat[r][c]);
                    r++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                    hrow    = out_row;
                end
            end
            @(negedge clk);
            t++;
        end
        if (t >= 500) check_eq("drain_timeout", r, M);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_ptr_row = '0; in_ptr_col = '0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_row", out_row, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_data", longint'(out_data == '0), 1);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);

        // Basic drain with latency and enable hold.
        send_matrix(0);
        check_eq("lat_1cyc", out_valid, 0);
        @(negedge clk);
        check_eq("lat_2cyc", out_valid, 1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("en0_valid", out_valid, 1);
        check_eq("en0_row", out_row, 0);
        check_eq("en0_in_ready", in_ready, 0);
        enable = 1'b1;
        set_exp(0);
        drain(1'b0);
        check_eq("post_drain_valid", out_valid, 0);

        // K accumulation: 3 + 5 - 2 per tile.
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                repeat (3) @(negedge clk);
                check_eq("k_not_ready", out_valid, 0);
            end
            send_tile(k / 2, k % 2, 1'b1, 1'b0, 3);
            send_tile(k / 2, k % 2, 1'b0, 1'b0, 5);
            send_tile(k / 2, k % 2, 1'b0, 1'b1, -2);
        end
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                exp_mat[r][c] = 6;
        drain(1'b0);

        // Ping-pong backpressure.
        out_ready = 1'b0;
        send_matrix(100);
        send_matrix(200);
        in_valid = 1'b1; in_ptr_row = '0; in_ptr_col = '0;
        check_eq("both_ready_in_ready", in_ready, 0);
        @(negedge clk);
        check_eq("both_ready_hold", in_ready, 0);
        in_valid = 1'b0;
        set_exp(100);
        drain(1'b0);
        check_eq("freed_in_ready", in_ready, 1);
        check_eq("bubble_valid", out_valid, 0);
        set_exp(200);
        drain(1'b0);

        // Output stall with random out_ready.
        out_ready = 1'b0;
        send_matrix(300);
        set_exp(300);
        drain(1'b1);

        // Error path, then reset mid-drain.
        out_ready = 1'b1;
        send_tile(2, 0, 1'b1, 1'b1, 7);
        check_eq("err_set", err, 1);
        check_eq("err_in_ready", in_ready, 1);
        send_tile(0, 0, 1'b1, 1'b1, 1);
        send_tile(0, 1, 1'b1, 1'b1, 1);
        send_tile(1, 0, 1'b1, 1'b1, 1);
        repeat (3) @(negedge clk);
        check_eq("err_not_counted", out_valid, 0);
        send_tile(1, 1, 1'b1, 1'b1, 1);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            check_eq("err_drain_start", out_valid, 1);
        end
        repeat (3) @(negedge clk);
        check_eq("mid_drain_row", out_row, 3);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_err", err, 0);
        check_eq("arst_row", out_row, 0);
        check_eq("arst_data", longint'(out_data == '0), 1);
        check_eq("arst_in_ready_en0", in_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_valid", out_valid, 0);
        enable = 1'b1;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        check_eq("post_rst_discard", out_valid, 0);

        // Saturation versus wrap: 30000 + 10000 in 16 bits.
        send_tile(0, 0, 1'b1, 1'b0, 30000);
        send_tile(0, 0, 1'b0, 1'b1, 10000);
        send_tile(0, 1, 1'b1, 1'b1, 0);
        send_tile(1, 0, 1'b1, 1'b1, 0);
        send_tile(1, 1, 1'b1, 1'b1, 0);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
`ifdef TC_PSUM_SAT_EN
                exp_mat[r][c] = (r < MT && c < NT) ? 32767 : 0;
`else
                exp_mat[r][c] = (r < MT && c < NT) ? -25536 : 0;
`endif
        drain(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
